// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, opcodes,
// state encoding, FIFO entry layout and the static branch predictor.
// Optional feature macro: IFU_STATIC_BPU_EN (static backward-branch / JAL prediction).
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package ifu_fetch_pkg;

   localparam int PC_W    = `PC_WIDTH;
   localparam int INSTR_W = `INSTR_WIDTH;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2,
      ST_HALT = 2'd3
   } ifu_state_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               prdt_taken;
      logic               misalign;
      logic               err;
   } ifu_entry_t;

   // Sign-extended J-type immediate
   function automatic logic [PC_W-1:0] imm_j(input logic [INSTR_W-1:0] i);
      return {{(PC_W-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   // Sign-extended B-type immediate
   function automatic logic [PC_W-1:0] imm_b(input logic [INSTR_W-1:0] i);
      return {{(PC_W-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   // JAL always taken, conditional branches taken only when backward.
   // Target arithmetic wraps naturally at PC_W bits.
   function automatic void static_predict(input  logic [PC_W-1:0]    pc,
                                          input  logic [INSTR_W-1:0] instr,
                                          output logic               taken,
                                          output logic [PC_W-1:0]    target);
      taken  = 1'b0;
      target = pc + PC_W'(4);
      if (instr[6:0] == OPC_JAL) begin
         taken  = 1'b1;
         target = pc + imm_j(instr);
      end else if ((instr[6:0] == OPC_BRANCH) && instr[31]) begin
         taken  = 1'b1;
         target = pc + imm_b(instr);
      end
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-bus interface of the fetch unit: request channel (valid/ready)
// and an always-accepted response channel.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface ifu_fetch_if;
   logic                    ifu_req_valid_o;
   logic [`PC_WIDTH-1:0]    ifu_req_addr_o;
   logic                    ifu_req_ready_i;
   logic                    ifu_rsp_valid_i;
   logic [`INSTR_WIDTH-1:0] ifu_rsp_instr_i;
   logic                    ifu_rsp_err_i;

   modport master (
      output ifu_req_valid_o,
      output ifu_req_addr_o,
      input  ifu_req_ready_i,
      input  ifu_rsp_valid_i,
      input  ifu_rsp_instr_i,
      input  ifu_rsp_err_i
   );

   modport slave (
      input  ifu_req_valid_o,
      input  ifu_req_addr_o,
      output ifu_req_ready_i,
      output ifu_rsp_valid_i,
      output ifu_rsp_instr_i,
      output ifu_rsp_err_i
   );
endinterface

// File: rtl/ifu_fetch_buf.sv
// Two-entry fetch FIFO with flush; flush wins over a simultaneous push/pop.
// Head is presented combinationally; caller masks it when empty.
module ifu_fetch_buf
   import ifu_fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush_i,
   input  logic       push_i,
   input  ifu_entry_t push_entry_i,
   input  logic       pop_i,
   output ifu_entry_t head_o,
   output logic [1:0] count_o
);

   localparam int DEPTH = 2;

   ifu_entry_t slot_vec [DEPTH];
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic [1:0] count_q, count_d;

   // Pointer and occupancy update; flush empties everything
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_i) wr_ptr_d = ~wr_ptr_q;
         if (pop_i)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         ifu_entry_t slot_q, slot_d;

         // Capture the pushed entry into the slot the write pointer selects
         always_comb begin
            slot_d = slot_q;
            if (!flush_i && push_i && (wr_ptr_q == 1'(gi))) slot_d = push_entry_i;
         end

         // Slot storage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) slot_q <= '0;
            else        slot_q <= slot_d;
         end

         assign slot_vec[gi] = slot_q;
      end
   endgenerate

   assign head_o  = slot_vec[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding bus fetcher feeding a 2-entry
// buffer towards ID, with EX redirect, bus-error and misalign halting.
// Optional feature macro: IFU_STATIC_BPU_EN (static prediction of JAL and
// backward conditional branches); without it the next PC is always pc+4.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [`PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ifu_fetch_if.master             ibus,
   input  logic                    ex_flush_i,
   input  logic [`PC_WIDTH-1:0]    ex_flush_pc_i,
   output logic                    IF_valid_o,
   input  logic                    ID_ready_i,
   output logic [`PC_WIDTH-1:0]    IF_pc_o,
   output logic [`INSTR_WIDTH-1:0] ifu_instr_o,
   output logic                    ifu_prdt_taken_o,
   output logic                    ifu_pc_misalign_o,
   output logic                    ifu_bus_err_o
);

   ifu_state_e       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;        // next fetch address, or outstanding one in WAIT
   logic             started_q, started_d;

   logic [1:0]       buf_count;
   ifu_entry_t       buf_head;
   ifu_entry_t       push_entry;
   logic             push, pop, if_valid;

   logic             rsp_prdt;
   logic [PC_W-1:0]  rsp_npc;
   logic [PC_W-1:0]  fetch_pc;
   logic             can_req, req_valid;
   logic [2:0]       cnt_after;

   assign if_valid = (buf_count != 2'd0);
   assign pop      = if_valid && ID_ready_i;

   // Successor of the outstanding request's PC (sequential or predicted)
   always_comb begin
      rsp_prdt = 1'b0;
      rsp_npc  = pc_q + PC_W'(4);
`ifdef IFU_STATIC_BPU_EN
      static_predict(pc_q, ibus.ifu_rsp_instr_i, rsp_prdt, rsp_npc);
`endif
   end

   // Next-state, push decision and request generation; flush overrides all
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      started_d  = 1'b1;
      push       = 1'b0;
      push_entry = '0;
      fetch_pc   = pc_q;
      can_req    = 1'b0;
      req_valid  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pc_q[1:0] != 2'b00) begin
               // Misaligned target: emit a marker entry once there is room, then stop
               if (({1'b0, buf_count} - {2'b00, pop}) < 3'd2) begin
                  push                = 1'b1;
                  push_entry.pc       = pc_q;
                  push_entry.misalign = 1'b1;
                  state_d             = ST_HALT;
               end
            end else begin
               can_req = 1'b1;
            end
         end
         ST_WAIT: begin
            if (ibus.ifu_rsp_valid_i) begin
               push             = 1'b1;
               push_entry.pc    = pc_q;
               push_entry.instr = ibus.ifu_rsp_instr_i;
               if (ibus.ifu_rsp_err_i) begin
                  push_entry.err = 1'b1;
                  state_d        = ST_HALT;
               end else begin
                  push_entry.prdt_taken = rsp_prdt;
                  state_d  = ST_IDLE;
                  pc_d     = rsp_npc;
                  fetch_pc = rsp_npc;
                  can_req  = 1'b1;
               end
            end
         end
         ST_DROP: begin
            // Discarded response returns; bus is free again this cycle
            if (ibus.ifu_rsp_valid_i) begin
               state_d = ST_IDLE;
               can_req = 1'b1;
            end
         end
         default: begin
         end
      endcase

      cnt_after = {1'b0, buf_count} - {2'b00, pop} + {2'b00, push};

      if (started_q && can_req && (fetch_pc[1:0] == 2'b00) &&
          (cnt_after <= 3'd1) && !ex_flush_i) begin
         req_valid = 1'b1;
         if (ibus.ifu_req_ready_i) begin
            state_d = ST_WAIT;
            pc_d    = fetch_pc;
         end
      end

      if (ex_flush_i) begin
         push       = 1'b0;
         push_entry = '0;
         pc_d       = ex_flush_pc_i;
         if (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !ibus.ifu_rsp_valid_i)
            state_d = ST_DROP;
         else
            state_d = ST_IDLE;
      end
   end

   // State, fetch PC and post-reset start flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         started_q <= started_d;
      end
   end

   ifu_fetch_buf u_buf (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (ex_flush_i),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (buf_head),
      .count_o      (buf_count)
   );

   assign ibus.ifu_req_valid_o = req_valid;
   assign ibus.ifu_req_addr_o  = fetch_pc;

   assign IF_valid_o        = if_valid;
   assign IF_pc_o           = if_valid ? buf_head.pc    : '0;
   assign ifu_instr_o       = if_valid ? buf_head.instr : '0;
   assign ifu_prdt_taken_o  = if_valid && buf_head.prdt_taken;
   assign ifu_pc_misalign_o = if_valid && buf_head.misalign;
   assign ifu_bus_err_o     = if_valid && buf_head.err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a bus model with configurable response
// latency, scenario tasks with hand-derived expectations.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_flush_i = 1'b0;
   logic [31:0] ex_flush_pc_i = '0;
   logic        IF_valid_o;
   logic        ID_ready_i = 1'b0;
   logic [31:0] IF_pc_o;
   logic [31:0] ifu_instr_o;
   logic        ifu_prdt_taken_o;
   logic        ifu_pc_misalign_o;
   logic        ifu_bus_err_o;

   ifu_fetch_if bus();

   ifu_fetch #(.RESET_PC(RST_PC)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ibus              (bus),
      .ex_flush_i        (ex_flush_i),
      .ex_flush_pc_i     (ex_flush_pc_i),
      .IF_valid_o        (IF_valid_o),
      .ID_ready_i        (ID_ready_i),
      .IF_pc_o           (IF_pc_o),
      .ifu_instr_o       (ifu_instr_o),
      .ifu_prdt_taken_o  (ifu_prdt_taken_o),
      .ifu_pc_misalign_o (ifu_pc_misalign_o),
      .ifu_bus_err_o     (ifu_bus_err_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // bus model state
   int          rsp_delay = 1;
   bit          pend_valid = 0;
   int          pend_wait = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   bit          jal_en = 0;

   // per-tick observations
   logic        o_req_valid, o_fire, o_ifv, o_prdt, o_mis, o_err;
   logic [31:0] o_req_addr, o_pc, o_instr;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        prdt;
      logic        mis;
      logic        err;
   } pop_t;
   pop_t        pop_q[$];
   logic [31:0] fire_q[$];

   // Instruction memory: ADDI-like words tagged with their address, plus
   // an optional "jal x0,-8" at 0x90.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (jal_en && (a == 32'h90)) return 32'hFF9F_F06F;
      return {a[24:0], 7'b0010011};
   endfunction

   // One clock cycle: drive inputs at negedge, sample #1 later, log transactions
   task automatic tick(input bit id_rdy, input bit flush, input logic [31:0] fpc);
      pop_t e;
      @(negedge clk);
      bus.ifu_rsp_valid_i = 1'b0;
      bus.ifu_rsp_instr_i = '0;
      bus.ifu_rsp_err_i   = 1'b0;
      if (pend_valid) begin
         if (pend_wait == 0) begin
            bus.ifu_rsp_valid_i = 1'b1;
            bus.ifu_rsp_instr_i = mem_word(pend_addr);
            bus.ifu_rsp_err_i   = (pend_addr == err_addr);
            pend_valid = 0;
         end else begin
            pend_wait--;
         end
      end
      ID_ready_i    = id_rdy;
      ex_flush_i    = flush;
      ex_flush_pc_i = fpc;
      #1;
      o_req_valid = bus.ifu_req_valid_o;
      o_req_addr  = bus.ifu_req_addr_o;
      o_fire      = bus.ifu_req_valid_o && bus.ifu_req_ready_i;
      o_ifv       = IF_valid_o;
      o_pc        = IF_pc_o;
      o_instr     = ifu_instr_o;
      o_prdt      = ifu_prdt_taken_o;
      o_mis       = ifu_pc_misalign_o;
      o_err       = ifu_bus_err_o;
      if (o_fire) begin
         pend_valid = 1;
         pend_wait  = rsp_delay - 1;
         pend_addr  = o_req_addr;
         fire_q.push_back(o_req_addr);
         $display("req  addr=%08h", o_req_addr);
      end
      if (o_ifv && id_rdy && !flush) begin
         e.pc = o_pc; e.instr = o_instr; e.prdt = o_prdt; e.mis = o_mis; e.err = o_err;
         pop_q.push_back(e);
         $display("pop  pc=%08h instr=%08h prdt=%0b mis=%0b err=%0b", o_pc, o_instr, o_prdt, o_mis, o_err);
      end
   endtask

   task automatic test_reset();
      bus.ifu_req_ready_i = 1'b1;
      bus.ifu_rsp_err_i   = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.ifu_rsp_valid_i = 1'b1;       // must be ignored while in reset
         bus.ifu_rsp_instr_i = 32'hDEAD_BEEF;
         #1;
         vectors++;
         if (bus.ifu_req_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_req_valid got=%b want=0", bus.ifu_req_valid_o);
         end
         vectors++;
         if ({IF_valid_o, IF_pc_o, ifu_instr_o, ifu_prdt_taken_o, ifu_pc_misalign_o, ifu_bus_err_o} !== '0) begin
            miscompares++; $display("FAIL reset_entry got v=%b pc=%h instr=%h want all 0", IF_valid_o, IF_pc_o, ifu_instr_o);
         end
      end
      @(negedge clk);
      bus.ifu_rsp_valid_i = 1'b0;
      bus.ifu_rsp_instr_i = '0;
      rst_n = 1'b1;
      #1;
      vectors++;
      if (bus.ifu_req_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL release_req_valid got=%b want=0 before first edge", bus.ifu_req_valid_o);
      end
   endtask

   task automatic test_stream();
      bit          fv[8];
      logic [31:0] fa[8];
      bit          iv[8];
      logic [31:0] ip[8];
      int          f = -1;
      for (int i = 0; i < 8; i++) begin
         tick(1, 0, '0);
         fv[i] = o_fire; fa[i] = o_req_addr; iv[i] = o_ifv; ip[i] = o_pc;
         if (o_fire && f < 0) f = i;
      end
      vectors++;
      if (f != 0) begin
         miscompares++; $display("FAIL first_req_cycle got=%0d want=0", f);
      end
      if (f < 0) f = 0;
      if (f > 5) f = 5;
      vectors++;
      if (!(fv[f] && fv[f+1] && fv[f+2]) || fa[f] !== 32'h80 || fa[f+1] !== 32'h84 || fa[f+2] !== 32'h88) begin
         miscompares++; $display("FAIL b2b_reqs got=%h,%h,%h want=00000080,00000084,00000088", fa[f], fa[f+1], fa[f+2]);
      end
      vectors++;
      if (iv[f+1] !== 1'b0 || iv[f+2] !== 1'b1 || ip[f+2] !== 32'h80) begin
         miscompares++; $display("FAIL first_if_valid got v1=%b v2=%b pc=%h want 0,1,00000080", iv[f+1], iv[f+2], ip[f+2]);
      end
   endtask

   task automatic test_backpressure();
      int          fires = 0;
      logic [31:0] exp_head;
      exp_head = RST_PC + 32'(4 * pop_q.size());
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, '0);
         if (o_fire) fires++;
      end
      vectors++;
      if (fires != 0) begin
         miscompares++; $display("FAIL stall_fires got=%0d want=0", fires);
      end
      vectors++;
      if (o_req_valid !== 1'b0 || o_ifv !== 1'b1 || o_pc !== exp_head) begin
         miscompares++; $display("FAIL stall_state got req=%b ifv=%b pc=%h want 0,1,%h", o_req_valid, o_ifv, o_pc, exp_head);
      end
      for (int i = 0; i < 6; i++) tick(1, 0, '0);
      vectors++;
      if (pop_q.size() < 10) begin
         miscompares++; $display("FAIL pop_count got=%0d want>=10", pop_q.size());
      end
      for (int k = 0; k < pop_q.size(); k++) begin
         vectors++;
         if (pop_q[k].pc !== RST_PC + 32'(4 * k) || pop_q[k].instr !== mem_word(pop_q[k].pc) ||
             pop_q[k].prdt !== 1'b0 || pop_q[k].err !== 1'b0 || pop_q[k].mis !== 1'b0) begin
            miscompares++; $display("FAIL order_%0d got pc=%h instr=%h want pc=%h instr=%h", k,
                                    pop_q[k].pc, pop_q[k].instr, RST_PC + 32'(4 * k), mem_word(RST_PC + 32'(4 * k)));
         end
      end
   endtask

   task automatic test_flush_drop();
      bit got = 0;
      rsp_delay = 2;
      for (int i = 0; i < 6 && !got; i++) begin
         tick(1, 0, '0);
         got = o_fire;
      end
      vectors++;
      if (!got) begin
         miscompares++; $display("FAIL flush_setup got no request want one");
      end
      tick(1, 1, 32'h200);                 // flush while the request is outstanding
      vectors++;
      if (o_req_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush_cycle_req got=%b want=0", o_req_valid);
      end
      rsp_delay = 1;
      pop_q.delete(); fire_q.delete();
      tick(1, 0, '0);                      // stale response arrives here
      vectors++;
      if (o_ifv !== 1'b0) begin
         miscompares++; $display("FAIL flush_empty got ifv=%b want=0", o_ifv);
      end
      vectors++;
      if (o_fire !== 1'b1 || o_req_addr !== 32'h200) begin
         miscompares++; $display("FAIL flush_req got fire=%b addr=%h want 1,00000200", o_fire, o_req_addr);
      end
      for (int i = 0; i < 4; i++) tick(1, 0, '0);
      vectors++;
      if (pop_q.size() < 2) begin
         miscompares++; $display("FAIL flush_pops got=%0d want>=2", pop_q.size());
      end else begin
         vectors++;
         if (pop_q[0].pc !== 32'h200 || pop_q[0].instr !== mem_word(32'h200) || pop_q[1].pc !== 32'h204) begin
            miscompares++; $display("FAIL flush_stream got %h/%h,%h want 00000200/%h,00000204",
                                    pop_q[0].pc, pop_q[0].instr, pop_q[1].pc, mem_word(32'h200));
         end
      end
   endtask

   task automatic test_bus_err();
      err_addr = 32'h84;
      tick(1, 1, 32'h80);
      pop_q.delete(); fire_q.delete();
      for (int i = 0; i < 8; i++) tick(1, 0, '0);
      vectors++;
      if (fire_q.size() != 2) begin
         miscompares++; $display("FAIL err_fires got=%0d want=2", fire_q.size());
      end
      vectors++;
      if (pop_q.size() != 2) begin
         miscompares++; $display("FAIL err_pops got=%0d want=2", pop_q.size());
      end else begin
         vectors++;
         if (pop_q[0].pc !== 32'h80 || pop_q[0].err !== 1'b0 || pop_q[1].pc !== 32'h84 || pop_q[1].err !== 1'b1) begin
            miscompares++; $display("FAIL err_entry got %h/err%b,%h/err%b want 00000080/err0,00000084/err1",
                                    pop_q[0].pc, pop_q[0].err, pop_q[1].pc, pop_q[1].err);
         end
      end
      vectors++;
      if (o_req_valid !== 1'b0 || o_ifv !== 1'b0) begin
         miscompares++; $display("FAIL err_halt got req=%b ifv=%b want 0,0", o_req_valid, o_ifv);
      end
      err_addr = 32'hFFFF_FFFF;
   endtask

   task automatic test_misalign();
      tick(0, 1, 32'h102);
      pop_q.delete(); fire_q.delete();
      tick(0, 0, '0);
      vectors++;
      if (o_req_valid !== 1'b0) begin
         miscompares++; $display("FAIL mis_req got=%b want=0", o_req_valid);
      end
      tick(0, 0, '0);
      vectors++;
      if (o_ifv !== 1'b1 || o_pc !== 32'h102 || o_mis !== 1'b1 || o_instr !== 32'h0 || o_err !== 1'b0) begin
         miscompares++; $display("FAIL mis_entry got v=%b pc=%h mis=%b instr=%h err=%b want 1,00000102,1,00000000,0",
                                 o_ifv, o_pc, o_mis, o_instr, o_err);
      end
      for (int i = 0; i < 4; i++) tick(1, 0, '0);
      vectors++;
      if (pop_q.size() != 1 || fire_q.size() != 0) begin
         miscompares++; $display("FAIL mis_halt got pops=%0d fires=%0d want 1,0", pop_q.size(), fire_q.size());
      end
      vectors++;
      if (o_ifv !== 1'b0 || o_pc !== 32'h0 || o_mis !== 1'b0) begin
         miscompares++; $display("FAIL idle_zero got v=%b pc=%h mis=%b want 0,00000000,0", o_ifv, o_pc, o_mis);
      end
   endtask

   task automatic test_predict();
      logic [31:0] exp_next;
      logic        exp_prdt;
`ifdef IFU_STATIC_BPU_EN
      exp_next = 32'h88; exp_prdt = 1'b1;
`else
      exp_next = 32'h94; exp_prdt = 1'b0;
`endif
      jal_en = 1;
      tick(1, 1, 32'h8C);
      pop_q.delete(); fire_q.delete();
      for (int i = 0; i < 6; i++) tick(1, 0, '0);
      vectors++;
      if (fire_q.size() < 3) begin
         miscompares++; $display("FAIL pred_fires got=%0d want>=3", fire_q.size());
      end else begin
         vectors++;
         if (fire_q[0] !== 32'h8C || fire_q[1] !== 32'h90 || fire_q[2] !== exp_next) begin
            miscompares++; $display("FAIL pred_next got %h,%h,%h want 0000008c,00000090,%h",
                                    fire_q[0], fire_q[1], fire_q[2], exp_next);
         end
      end
      vectors++;
      if (pop_q.size() < 3) begin
         miscompares++; $display("FAIL pred_pops got=%0d want>=3", pop_q.size());
      end else begin
         vectors++;
         if (pop_q[0].prdt !== 1'b0 || pop_q[1].pc !== 32'h90 || pop_q[1].prdt !== exp_prdt ||
             pop_q[1].instr !== 32'hFF9F_F06F || pop_q[2].pc !== exp_next) begin
            miscompares++; $display("FAIL pred_entry got prdt0=%b pc1=%h prdt1=%b pc2=%h want 0,00000090,%b,%h",
                                    pop_q[0].prdt, pop_q[1].pc, pop_q[1].prdt, pop_q[2].pc, exp_prdt, exp_next);
         end
      end
      jal_en = 0;
   endtask

   initial begin
      bus.ifu_req_ready_i = 1'b1;
      bus.ifu_rsp_valid_i = 1'b0;
      bus.ifu_rsp_instr_i = '0;
      bus.ifu_rsp_err_i   = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_drop();
      test_bus_err();
      test_misalign();
      test_predict();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
